// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared Montgomery state encoding, default width and counter sizing
package mont_pkg;

    localparam int MONT_K_BITS_DEFAULT = 256;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_LOAD  = LOAD,
        ST_SHIFT = SHIFT,
        ST_DONE  = DONE
    } mont_state_t;

    // One extra bit so the counter can represent K_BITS itself.
    function automatic int mont_cnt_width(input int k);
        return $clog2(k) + 1;
    endfunction

    localparam int MONT_CNT_W_DEFAULT = mont_cnt_width(MONT_K_BITS_DEFAULT);

endpackage

// File: rtl/montgomery_to_domain_if.sv
// rtl/montgomery_to_domain_if.sv - start/done handshake and operand bus for the domain converter
interface montgomery_to_domain_if #(
    parameter int K_BITS = 256
);
    logic              i_Start;
    logic [K_BITS-1:0] i_A;
    logic [K_BITS-1:0] i_m;
    logic [K_BITS-1:0] o_P;
    logic              o_Done;
    logic              o_Err;

    modport master (
        output i_Start, i_A, i_m,
        input  o_P, o_Done, o_Err
    );

    modport slave (
        input  i_Start, i_A, i_m,
        output o_P, o_Done, o_Err
    );
endinterface

// File: rtl/montgomery_mod_double.sv
// rtl/montgomery_mod_double.sv - combinational modular doubling: p_next = 2*p mod m, given p < m
module montgomery_mod_double #(
    parameter int K_BITS = 256
) (
    input  logic [K_BITS-1:0] p,
    input  logic [K_BITS-1:0] m,
    output logic [K_BITS-1:0] p_next
);
    logic [K_BITS:0]   t;
    logic [K_BITS+1:0] d;
    logic [K_BITS:0]   sel;
    logic              unused_sel_top;

    assign t = {p, 1'b0};
    assign d = {1'b0, t} - {2'b00, m};

    // t < 2m, so a single conditional subtract lands in [0, m); bit K is then always 0.
    assign sel            = d[K_BITS+1] ? t : d[K_BITS:0];
    assign p_next         = sel[K_BITS-1:0];
    assign unused_sel_top = sel[K_BITS];

endmodule

// File: rtl/montgomery_to_domain.sv
// rtl/montgomery_to_domain.sv - bit-serial A*2^K mod m converter; MONT_TO_DOMAIN_RANGE_CHECK_EN enables input range check
module montgomery_to_domain
    import mont_pkg::*;
#(
    parameter int K_BITS = MONT_K_BITS_DEFAULT
) (
    input logic                   i_Clk,
    input logic                   i_Rst,
    montgomery_to_domain_if.slave bus
);
    localparam int              CNT_W    = mont_cnt_width(K_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_BITS - 1);

    mont_state_t       state;
    mont_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [K_BITS-1:0] p;
    logic [K_BITS-1:0] p_dbl;
    logic              load_err;

`ifdef MONT_TO_DOMAIN_RANGE_CHECK_EN
    logic err;
    assign load_err   = (bus.i_A >= bus.i_m) || !bus.i_m[0];
    assign bus.o_Err  = err;
`else
    assign load_err   = 1'b0;
    assign bus.o_Err  = 1'b0;
`endif

    montgomery_mod_double #(.K_BITS(K_BITS)) u_mod_double (
        .p      (p),
        .m      (bus.i_m),
        .p_next (p_dbl)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            p     <= '0;
`ifdef MONT_TO_DOMAIN_RANGE_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_LOAD: begin
                    p   <= load_err ? '0 : bus.i_A;
                    cnt <= '0;
`ifdef MONT_TO_DOMAIN_RANGE_CHECK_EN
                    err <= load_err;
`endif
                end
                ST_SHIFT: begin
                    p   <= p_dbl;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // DONE waits for i_Start to drop so a held request cannot retrigger.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.i_Start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = load_err ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE:  if (!bus.i_Start) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign bus.o_P    = p;
    assign bus.o_Done = (state == ST_DONE);

endmodule

// File: tb/tb_montgomery_to_domain.sv
// tb/tb_montgomery_to_domain.sv - self-checking bench for 8-bit and 256-bit converter instances
module tb_montgomery_to_domain;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    montgomery_to_domain_if #(.K_BITS(8))   s8 ();
    montgomery_to_domain_if #(.K_BITS(256)) b256 ();

    montgomery_to_domain #(.K_BITS(8)) dut8 (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (s8)
    );

    montgomery_to_domain #(.K_BITS(256)) dut256 (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (b256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] ref_mont(input int k, input logic [255:0] a, input logic [255:0] m);
        logic [511:0] num;
        logic [511:0] rem;
        num = {256'b0, a} << k;
        rem = num % {256'b0, m};
        return rem[255:0];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic conv(input bit big, input logic [255:0] a, input logic [255:0] m,
                        output logic [255:0] p, output int lat, output logic err);
        logic dn;
        @(negedge clk);
        if (big) begin
            b256.i_A = a; b256.i_m = m; b256.i_Start = 1'b1;
        end else begin
            s8.i_A = a[7:0]; s8.i_m = m[7:0]; s8.i_Start = 1'b1;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            dn = big ? b256.o_Done : s8.o_Done;
        end while (!dn && lat < 600);
        p   = big ? b256.o_P : {248'b0, s8.o_P};
        err = big ? b256.o_Err : s8.o_Err;
        @(negedge clk);
        b256.i_Start = 1'b0;
        s8.i_Start   = 1'b0;
        @(posedge clk); #1;
        check("done_drops_after_start_low", big ? b256.o_Done : s8.o_Done, 256'd0);
    endtask

    initial begin
        logic [255:0] p, a, m;
        int           lat, first, ndone;
        logic         err;

        total = 0;
        bad   = 0;
        rst = 1'b1;
        s8.i_Start = 1'b0;   s8.i_A = '0;   s8.i_m = 8'd13;
        b256.i_Start = 1'b0; b256.i_A = '0; b256.i_m = 256'd13;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_done8", s8.o_Done, 256'd0);
        check("rst_p8",    s8.o_P,    256'd0);
        check("rst_err8",  s8.o_Err,  256'd0);
        check("rst_done256", b256.o_Done, 256'd0);
        check("rst_p256",    b256.o_P,    256'd0);
        check("rst_err256",  b256.o_Err,  256'd0);

        conv(1'b0, 256'd5, 256'd13, p, lat, err);
        check("m13_a5_p", p, 256'd6);
        check("m13_a5_lat", lat, 256'd10);
        check("m13_a5_err", err, 256'd0);

        conv(1'b0, 256'd254, 256'd255, p, lat, err);
        check("m255_a254_p", p, 256'd254);
        conv(1'b0, 256'd0, 256'd255, p, lat, err);
        check("a0_p", p, 256'd0);
        conv(1'b0, 256'd12, 256'd13, p, lat, err);
        check("m13_a12_p", p, 256'd4);

        // Start held for 30 cycles: one conversion, done held until start drops.
        @(negedge clk);
        s8.i_A = 8'd5; s8.i_m = 8'd13; s8.i_Start = 1'b1;
        first = 0; ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (s8.o_Done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        check("held_first_done", first, 256'd10);
        check("held_done_cycles", ndone, 256'd21);
        check("held_p", s8.o_P, 256'd6);
        @(negedge clk);
        s8.i_Start = 1'b0;
        @(posedge clk); #1;
        check("held_idle_done", s8.o_Done, 256'd0);
        @(posedge clk); #1;
        check("held_idle_stays", s8.o_Done, 256'd0);
        check("held_p_kept", s8.o_P, 256'd6);

        // Reset during the fourth SHIFT cycle.
        @(negedge clk);
        s8.i_A = 8'd12; s8.i_m = 8'd13; s8.i_Start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; s8.i_Start = 1'b0;
        @(posedge clk); #1;
        check("midrst_done", s8.o_Done, 256'd0);
        check("midrst_p", s8.o_P, 256'd0);
        check("midrst_err", s8.o_Err, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        conv(1'b0, 256'd12, 256'd13, p, lat, err);
        check("after_rst_p", p, 256'd4);
        check("after_rst_lat", lat, 256'd10);

        conv(1'b0, 256'd13, 256'd13, p, lat, err);
`ifdef MONT_TO_DOMAIN_RANGE_CHECK_EN
        check("rng_a_eq_m_lat", lat, 256'd2);
        check("rng_a_eq_m_err", err, 256'd1);
        check("rng_a_eq_m_p", p, 256'd0);
`else
        check("norng_a_eq_m_lat", lat, 256'd10);
        check("norng_a_eq_m_err", err, 256'd0);
`endif
        conv(1'b0, 256'd5, 256'd12, p, lat, err);
`ifdef MONT_TO_DOMAIN_RANGE_CHECK_EN
        check("rng_even_m_lat", lat, 256'd2);
        check("rng_even_m_err", err, 256'd1);
        check("rng_even_m_p", p, 256'd0);
`else
        check("norng_even_m_lat", lat, 256'd10);
        check("norng_even_m_err", err, 256'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            m = {248'b0, 8'($urandom)} | 256'd1;
            a = {224'b0, 32'($urandom)} % m;
            conv(1'b0, a, m, p, lat, err);
            check("rand8_p", p, ref_mont(8, a, m));
            check("rand8_err", err, 256'd0);
        end

        for (int i = 0; i < 40; i++) begin
            m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m[0] = 1'b1;
            a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % m;
            conv(1'b1, a, m, p, lat, err);
            check("rand256_p", p, ref_mont(256, a, m));
            check("rand256_lat", lat, 256'd258);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
